// File: rtl/bayer_window_5x5_pkg.sv
// Shared definitions for the 5x5 Bayer window generator and the downstream kernel selector.
package bayer_window_5x5_pkg;

  localparam int DW = 10;

  // Phase bits of the centre pixel, as combined by the kernel selector.
  localparam logic [1:0] ROW_ODD = 2'b10;
  localparam logic [1:0] COL_ODD = 2'b01;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } win_state_t;

  function automatic logic [1:0] bayer_phase(input logic row_odd, input logic col_odd);
    return (row_odd ? ROW_ODD : 2'b00) | (col_odd ? COL_ODD : 2'b00);
  endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// One line of pixel history: synchronous write, combinational read that returns the pre-write word.
module bayer_line_buffer #(
  parameter int DW    = 10,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bayer_window_5x5.sv
// 5x5 neighbourhood generator over a raster Bayer stream, with centre phase and frame-error flag.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | waiting for an in_sof pixel; other pixels dropped
// ST_ACTIVE | inside a frame, x/y track the next expected pixel
module bayer_window_5x5 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DW         = bayer_window_5x5_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] D11, D12, D13, D14, D15,
  output logic [DW-1:0] D21, D22, D23, D24, D25,
  output logic [DW-1:0] D31, D32, D33, D34, D35,
  output logic [DW-1:0] D41, D42, D43, D44, D45,
  output logic [DW-1:0] D51, D52, D53, D54, D55,
  output logic          out_valid,
  output logic          out_row_odd,
  output logic          out_col_odd,
  output logic          out_frame_err
);
  import bayer_window_5x5_pkg::*;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] LAST_X = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(IMG_HEIGHT - 1);

  win_state_t    state;
  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;
  logic          acc;
  logic [DW-1:0] lb_rd  [4];
  logic [DW-1:0] new_col[5];
  logic [DW-1:0] win    [5][5];

  // x/y hold the next expected coordinate; an sof pixel overrides them to (0,0).
  always_comb begin
    cur_x = in_sof ? '0 : x;
    cur_y = in_sof ? '0 : y;
  end

  assign acc = in_valid && ((state == ST_ACTIVE) || in_sof);

  for (genvar i = 0; i < 4; i++) begin : g_lb
    bayer_line_buffer #(
      .DW    (DW),
      .DEPTH (IMG_WIDTH),
      .AW    (XW)
    ) u_lb (
      .clk   (clk),
      .we    (acc && !rst),
      .addr  (cur_x),
      .wdata ((i == 0) ? in_data : lb_rd[(i == 0) ? 0 : i-1]),
      .rdata (lb_rd[i])
    );
  end

  always_comb begin
    new_col[0] = lb_rd[3];
    new_col[1] = lb_rd[2];
    new_col[2] = lb_rd[1];
    new_col[3] = lb_rd[0];
    new_col[4] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      out_valid     <= 1'b0;
      out_frame_err <= 1'b0;
      out_row_odd   <= 1'b0;
      out_col_odd   <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_frame_err <= 1'b0;
      if (acc) begin
        out_valid     <= (cur_x >= XW'(4)) && (cur_y >= YW'(4));
        out_frame_err <= in_sof && (state == ST_ACTIVE);
        // Centre is two back in both axes, so its parity equals the current one.
        out_row_odd   <= cur_y[0];
        out_col_odd   <= cur_x[0];
        if (cur_x == LAST_X) begin
          x <= '0;
          if (cur_y == LAST_Y) begin
            y     <= '0;
            state <= ST_IDLE;
          end else begin
            y     <= cur_y + 1'b1;
            state <= ST_ACTIVE;
          end
        end else begin
          x     <= cur_x + 1'b1;
          y     <= cur_y;
          state <= ST_ACTIVE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else if (acc) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++)
          win[r][c] <= win[r][c+1];
        win[r][4] <= new_col[r];
      end
    end
  end

  assign {D11, D12, D13, D14, D15} = {win[0][0], win[0][1], win[0][2], win[0][3], win[0][4]};
  assign {D21, D22, D23, D24, D25} = {win[1][0], win[1][1], win[1][2], win[1][3], win[1][4]};
  assign {D31, D32, D33, D34, D35} = {win[2][0], win[2][1], win[2][2], win[2][3], win[2][4]};
  assign {D41, D42, D43, D44, D45} = {win[3][0], win[3][1], win[3][2], win[3][3], win[3][4]};
  assign {D51, D52, D53, D54, D55} = {win[4][0], win[4][1], win[4][2], win[4][3], win[4][4]};

endmodule

// File: doc/bayer_window_5x5.md
# bayer_window_5x5

Upstream window generator for the 5x5 demosaic kernels, including the R/G/B interpolators such as R-at-G. It accepts a raster-order Bayer pixel stream with a valid qualifier and buffers four previous lines in line memories. For every interior pixel it presents the full 5x5 neighbourhood on D11..D55 as registered outputs, together with the Bayer phase of the centre pixel. Downstream kernel selection uses that phase.

## Interface
- IMG_WIDTH, 640, pixels per line (≥5)
- IMG_HEIGHT, 480, lines per frame (≥5)
- DW, 10, pixel width
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_sof qualify this cycle
- in_sof  input  1  first pixel of frame, valid only with in_valid
- in_data  input  DW  Bayer pixel, raster order
- D11..D15  output  DW each  window row y-4, columns x-4..x
- D21..D25  output  DW each  window row y-3
- D31..D35  output  DW each  window row y-2 (D33 = centre)
- D41..D45  output  DW each  window row y-1
- D51..D55  output  DW each  window row y (newest)
- out_valid  output  1  window valid, one pulse per interior centre
- out_row_odd  output  1  centre row parity, (y-2)[0]
- out_col_odd  output  1  centre column parity, (x-2)[0]
- out_frame_err  output  1  one-cycle pulse on an in_sof arriving mid-frame

## Operation
- No backpressure. Every accepted pixel (in_valid=1) is consumed. Idle cycles (in_valid=0) freeze all counters, buffers and window registers.
- FSM IDLE/ACTIVE:
  - IDLE: pixels are ignored unless in_sof=1. An accepted in_sof pixel is taken as (0,0) and moves the FSM to ACTIVE.
  - ACTIVE: after accepting the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1), return to IDLE.
  - ACTIVE with in_sof=1 on an accepted pixel: treat that pixel as (0,0) of a new frame, stay ACTIVE, pulse out_frame_err.
- Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) hold the coordinate of the accepted pixel. x wraps to 0 after IMG_WIDTH-1 and y increments at the same time.
- Four line buffers LB0..LB3, each IMG_WIDTH×DW:
  - On an accepted pixel, read address x from all four.
  - Write in_data→LB0[x], LB0 old→LB1[x], LB1 old→LB2[x], LB2 old→LB3[x].
  - Read-during-write returns old data.
- Window: a 5x5 register array. On an accept, every row shifts one column left; the new column enters at column 5 from {LB3,LB2,LB1,LB0,in_data} for rows 1..5.
- out_valid is asserted for an accept with x≥4 and y≥4, giving centre (x-2,y-2). Output count per frame is (IMG_WIDTH-4)×(IMG_HEIGHT-4).
- Border centres (within 2 pixels of any edge) are never output. No padding is applied and no end-of-frame flush is needed.
- Line buffer contents are not cleared by reset or sof. Stale data never reaches a valid window because of the x≥4/y≥4 gate.

## Timing
- Latency: D*, out_valid and the parity outputs update on the clock edge that accepts the completing pixel, i.e. one cycle after in_valid is sampled. The window corresponds to the pixel just accepted.
- out_valid is a single-cycle pulse. D* hold their value until the next accept.
- Reset:
  - out_valid=0, out_frame_err=0, out_row_odd=0, out_col_odd=0, all D*=0.
  - x=y=0, FSM=IDLE.
  - Reset mid-frame aborts the frame; the next valid data requires in_sof.
- Simultaneous rst and in_valid: rst wins and the pixel is dropped.
- Mid-frame sof: the window registers are not cleared, but the new frame's first valid window still appears only at its own (4,4).

## Structure
- Shared package holds DW and the phase encoding constants (ROW_ODD, COL_ODD) used by the downstream kernel selector.
- One sub-module, bayer_line_buffer: single-port-addressed, DW-wide, depth IMG_WIDTH, synchronous write, old-data read. Instantiate it four times.
- Counter and FSM logic plus the 5x5 register array stay in the top level.

## Test plan
- **Ramp frame.** IMG_WIDTH=8, IMG_HEIGHT=6, pixel = y·16+x, continuous valid.
  - First out_valid after accepting (4,4), with D11=0x000, D33=0x022, D55=0x044, D15=0x004, D51=0x040.
  - Exactly 8 out_valid pulses.
- **Gapped input.** Same frame with random in_valid gaps → identical window sequence and count; nothing changes during gaps.
- **Phase.** Check out_row_odd/out_col_odd against the centre coordinates: first window (2,2) gives 0/0; the next gives 0/1; the first window of the next output row gives 1/0.
- **Mid-frame sof.** Assert in_sof at (3,3) → out_frame_err pulses once; counting restarts; the next out_valid occurs 4 lines + 4 pixels later with D11 = the new frame's (0,0).
- **Reset mid-frame.** Assert rst during row 4 → all outputs 0 the next cycle; pixels without sof are ignored; a subsequent full frame gives the nominal 8 windows.
- **Full scale.** All pixels 0x3FF → every D* = 0x3FF with no truncation; pixels before the first sof produce no out_valid.
